alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised successor to the SAP-1 8-bit add/subtract ALU.
- Adds eight operations, registered status flags, and an iterative shift-add multiplier.
- Uses a start/busy/done handshake driven by the controller sequencer.
- Result drives the shared tri-state bus only while the send enable is high.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- OP_W, 3, opcode width (fixed at 3 for the 8-op set).

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_a  input  WIDTH  operand A (accumulator).
- i_b  input  WIDTH  operand B (B register).
- i_op  input  OP_W  operation select, sampled on start.
- i_start  input  1  one-cycle start pulse.
- i_send_enable  input  1  drive result onto bus.
- o_bus  output  WIDTH  result when i_send_enable=1, else all Z.
- o_busy  output  1  operation in progress.
- o_done  output  1  one-cycle pulse when result/flags are updated.
- o_carry  output  1  carry/borrow/shift-out/multiply-overflow flag.
- o_zero  output  1  result == 0.
- o_negative  output  1  result MSB.
- o_overflow  output  1  signed overflow (ADD/SUB only, else 0).

Behaviour:
- Reset (async, any state): FSM to IDLE; result register, all flags, o_busy and o_done = 0. o_bus = 0 if i_send_enable=1, else Z. A multiply in progress is discarded.
- o_bus is combinational from the result register and i_send_enable. Result changes only at o_done, never mid-operation.
- Opcodes: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SHL (A<<1), 110 SHR (logical A>>1), 111 MUL (unsigned A*B, low WIDTH bits).
- FSM states: IDLE, MUL, DONE.
- IDLE + i_start, op != MUL: i_a, i_b, i_op captured. Result and flags written at that same edge; o_done=1 in the following cycle; FSM moves to DONE. Latency is 1 cycle.
- IDLE + i_start, op == MUL: operands latched; o_busy=1; FSM moves to MUL. One multiplier bit is processed per cycle for WIDTH cycles. On the last iteration, result/flags are written, FSM moves to DONE, and o_done pulses. Latency from start to o_done is WIDTH+1 cycles.
- DONE: lasts one cycle with o_done=1, o_busy=0, then returns to IDLE. i_start in DONE is ignored.
- i_start while in MUL is ignored; no queueing.
- i_a/i_b may change after start without affecting an in-flight multiply.
- Flags are updated only at result write and hold until the next write:
  - ADD: carry = bit WIDTH of the sum.
  - SUB: carry = borrow (1 when A<B unsigned).
  - Overflow: ADD when operand signs match and result sign differs; SUB when operand signs differ and result sign differs from A.
  - AND/OR/XOR: carry = 0, overflow = 0.
  - SHL: carry = A[WIDTH-1]. SHR: carry = A[0].
  - MUL: carry = 1 when any of the upper WIDTH bits of the full 2*WIDTH product is nonzero; overflow = 0.
  - zero and negative always derive from the WIDTH-bit result.
- Arithmetic is modulo 2^WIDTH; wrap-around is silent apart from the flags.
- An unknown/X opcode must not occur; the bench does not drive one.

Decomposition:
- Package alu_pkg:
  - op enum (OP_ADD..OP_MUL, 3 bits);
  - FSM state enum (ST_IDLE, ST_MUL, ST_DONE);
  - flag index constants.
- Sub-module alu_mul_seq: iterative shift-add multiplier.
  - Inputs: clk, reset, load, a, b.
  - Outputs: 2*WIDTH product, last-step strobe.
  - Contains its own WIDTH-bit iteration counter.
- Top level holds the FSM, the single-cycle datapath, the flag logic and the tri-state bus driver.

Test Plan:
- Reset mid-MUL (WIDTH=8): start MUL 12*11, assert i_reset at cycle 4 -> o_busy=0, result 0, flags 0, o_done never pulses; a following ADD 1+1 gives 2.
- ADD boundary: A=8'hFF, B=8'h01 -> result 8'h00, carry=1, zero=1, overflow=0, o_done exactly 1 cycle after start; A=8'h7F, B=8'h01 -> 8'h80, overflow=1, negative=1.
- SUB borrow: A=8'h03, B=8'h05 -> result 8'hFE, carry=1, negative=1; A=8'h80, B=8'h01 -> 8'h7F, overflow=1.
- MUL: A=12, B=11 -> 132 (8'h84), carry=0, o_done at start+9; A=8'h10, B=8'h10 -> 8'h00, carry=1, zero=1. Changing i_a mid-op and issuing i_start during busy both have no effect.
- Shifts/logic: SHL 8'h81 -> 8'h02, carry=1; SHR 8'h81 -> 8'h40, carry=1; XOR 8'hAA^8'hAA -> 0, zero=1, carry=0.
- Bus: i_send_enable=0 -> o_bus all Z; =1 -> last result, stable across a subsequent in-flight MUL until its o_done.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU.
//   op_e    : 3-bit operation select (ADD..MUL)
//   state_e : controller FSM states (IDLE, MUL, DONE)
//   FLAG_*  : bit positions inside the packed status-flag vector
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned FLAG_C    = 0;
  localparam int unsigned FLAG_Z    = 1;
  localparam int unsigned FLAG_N    = 2;
  localparam int unsigned FLAG_V    = 3;
  localparam int unsigned NUM_FLAGS = 4;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
//   i_clk, i_reset : clock, async active-high reset (discards any run)
//   i_load         : latch i_a/i_b and start a WIDTH-step run
//   i_a, i_b       : multiplicand / multiplier
//   o_product      : 2*WIDTH product including the current step
//   o_last         : high during the final step; o_product is then complete
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_product,
  output logic               o_last
);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   cnt_q;
  logic               run_q;

  // The product is exposed one step ahead of acc_q so the controller can
  // write the result on the same edge that retires the last step.
  always_comb begin
    acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    o_product = acc_d;
    o_last    = run_q && (cnt_q == WIDTH'(WIDTH - 1));
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (i_load) begin
      mcand_q  <= {{WIDTH{1'b0}}, i_a};
      mplier_q <= i_b;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (o_last) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: eight operations, registered status flags, iterative
// multiply, start/busy/done handshake and a tri-state result bus.
//   i_clk, i_reset   : clock, async active-high reset
//   i_a, i_b, i_op   : operands and operation, sampled on i_start in IDLE
//   i_start          : one-cycle start pulse (ignored unless IDLE)
//   i_send_enable    : drive the result register onto o_bus
//   o_bus            : result when enabled, else high impedance
//   o_busy, o_done   : multiply in progress / one-cycle completion pulse
//   o_carry, o_zero, o_negative, o_overflow : registered status flags
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OP_W  = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [OP_W-1:0]  i_op,
  input  logic             i_start,
  input  logic             i_send_enable,
  output logic [WIDTH-1:0] o_bus,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_carry,
  output logic             o_zero,
  output logic             o_negative,
  output logic             o_overflow
);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic [NUM_FLAGS-1:0]   flags_q, flags_d;

  op_e                    op;
  logic [WIDTH:0]         sum_w;
  logic [WIDTH:0]         diff_w;
  logic [WIDTH-1:0]       alu_res;
  logic                   alu_c;
  logic                   alu_v;

  logic                   mul_load;
  logic [2*WIDTH-1:0]     mul_product;
  logic                   mul_last;

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (mul_load),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_product (mul_product),
    .o_last    (mul_last)
  );

  // Single-cycle datapath on the live operands.
  always_comb begin
    op      = op_e'(i_op);
    sum_w   = {1'b0, i_a} + {1'b0, i_b};
    diff_w  = {1'b0, i_a} - {1'b0, i_b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (op)
      OP_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_w[WIDTH-1:0];
        alu_c   = diff_w[WIDTH];  // borrow out of the MSB
        alu_v   = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_AND: alu_res = i_a & i_b;
      OP_OR:  alu_res = i_a | i_b;
      OP_XOR: alu_res = i_a ^ i_b;
      OP_SHL: begin
        alu_res = i_a << 1;
        alu_c   = i_a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = i_a >> 1;
        alu_c   = i_a[0];
      end
      default: alu_res = '0;  // OP_MUL goes through the multiplier
    endcase
  end

  // Controller: next state plus result/flag write.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    mul_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (op == OP_MUL) begin
            mul_load = 1'b1;
            state_d  = ST_MUL;
          end else begin
            result_d         = alu_res;
            flags_d[FLAG_C]  = alu_c;
            flags_d[FLAG_Z]  = (alu_res == '0);
            flags_d[FLAG_N]  = alu_res[WIDTH-1];
            flags_d[FLAG_V]  = alu_v;
            state_d          = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        if (mul_last) begin
          result_d         = mul_product[WIDTH-1:0];
          flags_d[FLAG_C]  = |mul_product[2*WIDTH-1:WIDTH];
          flags_d[FLAG_Z]  = (mul_product[WIDTH-1:0] == '0);
          flags_d[FLAG_N]  = mul_product[WIDTH-1];
          flags_d[FLAG_V]  = 1'b0;
          state_d          = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign o_busy     = (state_q == ST_MUL);
  assign o_done     = (state_q == ST_DONE);
  assign o_carry    = flags_q[FLAG_C];
  assign o_zero     = flags_q[FLAG_Z];
  assign o_negative = flags_q[FLAG_N];
  assign o_overflow = flags_q[FLAG_V];
  assign o_bus      = i_send_enable ? result_q : 'z;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int W = 8;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic [W-1:0] i_a, i_b;
  logic [2:0]   i_op;
  logic         i_start, i_send_enable;
  logic [W-1:0] o_bus;
  logic         o_busy, o_done, o_carry, o_zero, o_negative, o_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(W), .OP_W(3)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_a(i_a), .i_b(i_b), .i_op(i_op),
    .i_start(i_start), .i_send_enable(i_send_enable), .o_bus(o_bus),
    .o_busy(o_busy), .o_done(o_done), .o_carry(o_carry), .o_zero(o_zero),
    .o_negative(o_negative), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  // Reference: {result[7:0], carry, zero, negative, overflow} from plain arithmetic.
  function automatic logic [11:0] model(input int op, input int a, input int b);
    int r, s, sa, sb;
    logic c, v;
    logic [7:0] rb;
    c = 1'b0; v = 1'b0; r = 0;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (op)
      0: begin r = a + b; c = (r >= 256); s = sa + sb; v = (s > 127) || (s < -128); end
      1: begin r = a - b; c = (a < b);    s = sa - sb; v = (s > 127) || (s < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a * 2; c = (a >= 128); end
      6: begin r = a / 2; c = ((a % 2) == 1); end
      default: begin r = a * b; c = (r >= 256); end
    endcase
    r  = ((r % 256) + 256) % 256;
    rb = r[7:0];
    return {rb, c, (rb == 8'h00), rb[7], v};
  endfunction

  // Drive one operation from IDLE; report bus value, flags and latency at o_done.
  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] res, output logic [3:0] fl, output int lat);
    i_op = op; i_a = a; i_b = b; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_a = 8'($urandom); i_b = 8'($urandom);
    lat = 1;
    while (o_done !== 1'b1 && lat < 40) begin
      @(posedge i_clk); #1;
      lat++;
    end
    res = o_bus;
    fl  = {o_carry, o_zero, o_negative, o_overflow};
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset;
    logic [7:0] zz;
    zz = 8'hzz;
    i_reset = 1'b1; i_start = 1'b0; i_send_enable = 1'b1;
    i_a = '0; i_b = '0; i_op = '0;
    repeat (2) @(posedge i_clk);
    #1;
    n_checks += 4;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_handshake busy=%b done=%b want 0 0", o_busy, o_done);
    end
    if ({o_carry, o_zero, o_negative, o_overflow} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {o_carry, o_zero, o_negative, o_overflow});
    end
    if (o_bus !== 8'h00) begin
      n_fail++; $display("FAIL reset_bus got %h want 00", o_bus);
    end
    i_send_enable = 1'b0; #1;
    if (o_bus !== zz) begin
      n_fail++; $display("FAIL reset_bus_z got %h want zz", o_bus);
    end
    i_send_enable = 1'b1;
    i_reset = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_add_sub;
    logic [7:0]  ta[6], tb_[6], res;
    logic [2:0]  top[6];
    logic [3:0]  fl;
    logic [11:0] exp;
    int lat;
    ta  = '{8'hFF, 8'h7F, 8'h03, 8'h80, 8'h40, 8'h00};
    tb_ = '{8'h01, 8'h01, 8'h05, 8'h01, 8'h40, 8'h00};
    top = '{3'd0,  3'd0,  3'd1,  3'd1,  3'd0,  3'd1};
    for (int i = 0; i < 6; i++) begin
      do_op(top[i], ta[i], tb_[i], res, fl, lat);
      exp = model(int'(top[i]), int'(ta[i]), int'(tb_[i]));
      n_checks += 3;
      if (res !== exp[11:4]) begin
        n_fail++; $display("FAIL addsub_result op=%0d a=%h b=%h got %h want %h", top[i], ta[i], tb_[i], res, exp[11:4]);
      end
      if (fl !== exp[3:0]) begin
        n_fail++; $display("FAIL addsub_flags op=%0d a=%h b=%h got %b want %b", top[i], ta[i], tb_[i], fl, exp[3:0]);
      end
      if (lat != 1) begin
        n_fail++; $display("FAIL addsub_latency op=%0d got %0d want 1", top[i], lat);
      end
    end
  endtask

  task automatic test_logic_shift;
    logic [7:0]  ta[5], tb_[5], res;
    logic [2:0]  top[5];
    logic [3:0]  fl;
    logic [11:0] exp;
    int lat;
    ta  = '{8'h81, 8'h81, 8'hAA, 8'hF0, 8'hC3};
    tb_ = '{8'h00, 8'h00, 8'hAA, 8'h0F, 8'h5A};
    top = '{3'd5,  3'd6,  3'd4,  3'd3,  3'd2};
    for (int i = 0; i < 5; i++) begin
      do_op(top[i], ta[i], tb_[i], res, fl, lat);
      exp = model(int'(top[i]), int'(ta[i]), int'(tb_[i]));
      n_checks += 3;
      if (res !== exp[11:4]) begin
        n_fail++; $display("FAIL logic_result op=%0d a=%h b=%h got %h want %h", top[i], ta[i], tb_[i], res, exp[11:4]);
      end
      if (fl !== exp[3:0]) begin
        n_fail++; $display("FAIL logic_flags op=%0d a=%h b=%h got %b want %b", top[i], ta[i], tb_[i], fl, exp[3:0]);
      end
      if (lat != 1) begin
        n_fail++; $display("FAIL logic_latency op=%0d got %0d want 1", top[i], lat);
      end
    end
  endtask

  task automatic test_mul;
    logic [7:0]  res, prev;
    logic [3:0]  fl;
    logic [11:0] exp;
    int lat;
    do_op(3'd0, 8'h02, 8'h03, res, fl, lat);
    prev = o_bus;
    // 12*11 with i_a scrambled and a stray start while busy; bus must hold prev.
    i_op = 3'd7; i_a = 8'd12; i_b = 8'd11; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_a = 8'hFF; i_b = 8'h77;
    lat = 1;
    while (o_done !== 1'b1 && lat < 40) begin
      n_checks += 2;
      if (o_busy !== 1'b1) begin
        n_fail++; $display("FAIL mul_busy cycle=%0d got %b want 1", lat, o_busy);
      end
      if (o_bus !== prev) begin
        n_fail++; $display("FAIL mul_bus_stable cycle=%0d got %h want %h", lat, o_bus, prev);
      end
      if (lat == 3) begin i_start = 1'b1; i_op = 3'd0; end
      else i_start = 1'b0;
      @(posedge i_clk); #1;
      lat++;
    end
    i_start = 1'b0;
    exp = model(7, 12, 11);
    n_checks += 4;
    if (lat != 9) begin
      n_fail++; $display("FAIL mul_latency got %0d want 9", lat);
    end
    if (o_bus !== exp[11:4]) begin
      n_fail++; $display("FAIL mul_result got %h want %h", o_bus, exp[11:4]);
    end
    if ({o_carry, o_zero, o_negative, o_overflow} !== exp[3:0]) begin
      n_fail++; $display("FAIL mul_flags got %b want %b", {o_carry, o_zero, o_negative, o_overflow}, exp[3:0]);
    end
    if (o_busy !== 1'b0) begin
      n_fail++; $display("FAIL mul_busy_at_done got %b want 0", o_busy);
    end
    @(posedge i_clk); #1;
    do_op(3'd7, 8'h10, 8'h10, res, fl, lat);
    exp = model(7, 16, 16);
    n_checks += 3;
    if (res !== exp[11:4]) begin
      n_fail++; $display("FAIL mul_ovf_result got %h want %h", res, exp[11:4]);
    end
    if (fl !== exp[3:0]) begin
      n_fail++; $display("FAIL mul_ovf_flags got %b want %b", fl, exp[3:0]);
    end
    if (lat != 9) begin
      n_fail++; $display("FAIL mul_ovf_latency got %0d want 9", lat);
    end
  endtask

  task automatic test_reset_mid_mul;
    logic [7:0] res;
    logic [3:0] fl;
    int lat, seen;
    do_op(3'd0, 8'h20, 8'h03, res, fl, lat);
    i_op = 3'd7; i_a = 8'd12; i_b = 8'd11; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (3) begin @(posedge i_clk); #1; end
    i_reset = 1'b1; #1;
    n_checks += 3;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL midreset_handshake busy=%b done=%b want 0 0", o_busy, o_done);
    end
    if (o_bus !== 8'h00) begin
      n_fail++; $display("FAIL midreset_result got %h want 00", o_bus);
    end
    if ({o_carry, o_zero, o_negative, o_overflow} !== 4'b0000) begin
      n_fail++; $display("FAIL midreset_flags got %b want 0000", {o_carry, o_zero, o_negative, o_overflow});
    end
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge i_clk); #1;
      if (o_done === 1'b1 || o_busy === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL midreset_no_done got %0d active cycles want 0", seen);
    end
    do_op(3'd0, 8'h01, 8'h01, res, fl, lat);
    n_checks += 2;
    if (res !== 8'h02) begin
      n_fail++; $display("FAIL midreset_add got %h want 02", res);
    end
    if (lat != 1) begin
      n_fail++; $display("FAIL midreset_add_latency got %0d want 1", lat);
    end
  endtask

  task automatic test_bus_z;
    logic [7:0] zz, res;
    logic [3:0] fl;
    int lat;
    zz = 8'hzz;
    do_op(3'd3, 8'h5A, 8'h81, res, fl, lat);
    i_send_enable = 1'b0; #1;
    n_checks += 2;
    if (o_bus !== zz) begin
      n_fail++; $display("FAIL bus_z got %h want zz", o_bus);
    end
    i_send_enable = 1'b1; #1;
    if (o_bus !== 8'hDB) begin
      n_fail++; $display("FAIL bus_drive got %h want db", o_bus);
    end
  endtask

  task automatic test_back_to_back;
    i_op = 3'd4; i_a = 8'h05; i_b = 8'h03; i_start = 1'b1;
    @(posedge i_clk); #1;
    // Now in DONE: this start must be ignored.
    i_op = 3'd0; i_a = 8'h01; i_b = 8'h01;
    n_checks++;
    if (o_done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_done got %b want 1", o_done);
    end
    @(posedge i_clk); #1;
    i_start = 1'b0;
    n_checks += 2;
    if (o_done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ignored_done got %b want 0", o_done);
    end
    if (o_bus !== 8'h06) begin
      n_fail++; $display("FAIL b2b_ignored_result got %h want 06", o_bus);
    end
    @(posedge i_clk); #1;
    n_checks++;
    if (o_done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle_done got %b want 0", o_done);
    end
  endtask

  task automatic test_random;
    logic [7:0]  a, b, res;
    logic [2:0]  op;
    logic [3:0]  fl;
    logic [11:0] exp;
    int lat;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      do_op(op, a, b, res, fl, lat);
      exp = model(int'(op), int'(a), int'(b));
      n_checks += 3;
      if (res !== exp[11:4]) begin
        n_fail++; $display("FAIL rand_result op=%0d a=%h b=%h got %h want %h", op, a, b, res, exp[11:4]);
      end
      if (fl !== exp[3:0]) begin
        n_fail++; $display("FAIL rand_flags op=%0d a=%h b=%h got %b want %b", op, a, b, fl, exp[3:0]);
      end
      if (lat != ((op == 3'd7) ? 9 : 1)) begin
        n_fail++; $display("FAIL rand_latency op=%0d got %0d", op, lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic_shift();
    test_mul();
    test_reset_mid_mul();
    test_bus_z();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
